// File: rtl/shift_controller_pkg.sv
// ---------------------------------------------------------------------------
// shift_controller_pkg : FSM state and direction/operation encodings shared
//                        by shift_controller and its shifter datapath.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic c_DIR_LEFT  = 1'b1;
  localparam logic c_DIR_RIGHT = 1'b0;
  localparam logic c_OP_ROTATE = 1'b1;
  localparam logic c_OP_SHIFT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/shift_controller_shifter.sv
// ---------------------------------------------------------------------------
// shift_controller_shifter : iterative one-bit-per-cycle shifter/rotator.
// o_finished pulses for one cycle when the loaded count reaches zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_controller_shifter
  import shift_controller_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_direction,
  input  logic         i_rotate,
  input  logic [N-1:0] i_iterations,
  input  logic [N-1:0] i_value,
  output logic         o_finished,
  output logic [N-1:0] o_value
);

  logic [N-1:0] r_value;
  logic [N-1:0] r_count;
  logic         r_active;
  logic [N-1:0] w_step;

  always_comb begin
    w_step = r_value;
    unique case ({i_direction, i_rotate})
      {c_DIR_LEFT,  c_OP_SHIFT}:  w_step = {r_value[N-2:0], 1'b0};
      {c_DIR_LEFT,  c_OP_ROTATE}: w_step = {r_value[N-2:0], r_value[N-1]};
      {c_DIR_RIGHT, c_OP_SHIFT}:  w_step = {1'b0, r_value[N-1:1]};
      {c_DIR_RIGHT, c_OP_ROTATE}: w_step = {r_value[0], r_value[N-1:1]};
      default:                    w_step = r_value;
    endcase
  end

  assign o_finished = r_active && (r_count == '0);
  assign o_value    = r_value;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_value  <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_value  <= i_value;
      r_count  <= i_iterations;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_value <= w_step;
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_controller.sv
// ---------------------------------------------------------------------------
// shift_controller : valid/ready command wrapper around the iterative shifter.
// Optional macro SHIFT_CONTROLLER_CLAMP_EN reduces the count at latch time.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_controller
  import shift_controller_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic         i_cmd_direction,
  input  logic         i_cmd_rotate,
  input  logic [N-1:0] i_cmd_iterations,
  input  logic [N-1:0] i_cmd_value,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [N-1:0] o_rsp_value,
  output logic         o_busy
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_direction;
  logic         r_rotate;
  logic [N-1:0] r_iterations;
  logic [N-1:0] r_value;
  logic [N-1:0] r_rsp_value;
  logic [N-1:0] w_latch_iterations;
  logic         w_start;
  logic         w_finished;
  logic [N-1:0] w_shifter_value;
  logic         w_accept;
  logic         w_capture;

`ifdef SHIFT_CONTROLLER_CLAMP_EN
  localparam logic [N-1:0] c_N_COUNT  = N'(N);
  localparam logic [N-1:0] c_ROT_MASK = N'(N - 1);

  // Shifts saturate at N (result already all-zero); rotates wrap modulo N.
  always_comb begin
    w_latch_iterations = i_cmd_iterations;
    if (i_cmd_rotate == c_OP_ROTATE)
      w_latch_iterations = i_cmd_iterations & c_ROT_MASK;
    else if (i_cmd_iterations > c_N_COUNT)
      w_latch_iterations = c_N_COUNT;
  end
`else
  assign w_latch_iterations = i_cmd_iterations;
`endif

  assign w_accept    = (r_state == IDLE) && i_cmd_valid;
  assign w_capture   = ((r_state == START) || (r_state == WAIT)) && w_finished;
  assign w_start     = (r_state == START);
  assign o_cmd_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_rsp_value = r_rsp_value;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (i_cmd_valid) w_next_state = START;
      START:   w_next_state = w_finished ? DONE : WAIT;
      WAIT:    if (w_finished) w_next_state = DONE;
      DONE:    if (i_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_direction  <= 1'b0;
      r_rotate     <= 1'b0;
      r_iterations <= '0;
      r_value      <= '0;
      r_rsp_value  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_direction  <= i_cmd_direction;
        r_rotate     <= i_cmd_rotate;
        r_iterations <= w_latch_iterations;
        r_value      <= i_cmd_value;
      end
      if (w_capture)
        r_rsp_value <= w_shifter_value;
    end
  end

  shift_controller_shifter #(
    .N (N)
  ) u_shifter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (w_start),
    .i_direction  (r_direction),
    .i_rotate     (r_rotate),
    .i_iterations (r_iterations),
    .i_value      (r_value),
    .o_finished   (w_finished),
    .o_value      (w_shifter_value)
  );

endmodule

`default_nettype wire

// File: tb/tb_shift_controller.sv
// ---------------------------------------------------------------------------
// tb_shift_controller : directed self-checking bench for shift_controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_controller;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_direction;
  logic         cmd_rotate;
  logic [N-1:0] cmd_iterations;
  logic [N-1:0] cmd_value;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_value;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_controller #(.N(N)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_direction  (cmd_direction),
    .i_cmd_rotate     (cmd_rotate),
    .i_cmd_iterations (cmd_iterations),
    .i_cmd_value      (cmd_value),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_value      (rsp_value),
    .o_busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers a command at a negedge and returns once the accepting edge has passed.
  task automatic issue(input logic dir, input logic rot, input logic [N-1:0] iters,
                       input logic [N-1:0] value);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid      = 1'b1;
    cmd_direction  = dir;
    cmd_rotate     = rot;
    cmd_iterations = iters;
    cmd_value      = value;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts edges after acceptance until o_rsp_valid is observed.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic dir, input logic rot,
                        input logic [N-1:0] iters, input logic [N-1:0] value,
                        input logic [N-1:0] exp_value, input int exp_lat);
    int lat;
    issue(dir, rot, iters, value);
    @(posedge clk);
    #1;
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_val"}, 32'(rsp_value), 32'(exp_value));
    take_rsp();
  endtask

  initial begin
    int lat;
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_direction  = 1'b0;
    cmd_rotate     = 1'b0;
    cmd_iterations = '0;
    cmd_value      = '0;
    rsp_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_value", 32'(rsp_value), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);

    run_op("shl_81_3",  1'b1, 1'b0, 8'd3, 8'h81, 8'h08, 5);
    run_op("ror_01_1",  1'b0, 1'b1, 8'd1, 8'h01, 8'h80, 3);
    run_op("rol_80_1",  1'b1, 1'b1, 8'd1, 8'h80, 8'h01, 3);
    run_op("zero_a5",   1'b1, 1'b0, 8'd0, 8'hA5, 8'hA5, 2);
    run_op("shr_a5_2",  1'b0, 1'b0, 8'd2, 8'hA5, 8'h29, 4);
`ifdef SHIFT_CONTROLLER_CLAMP_EN
    run_op("rol_01_9",  1'b1, 1'b1, 8'd9,   8'h01, 8'h02, 3);
    run_op("shl_01_8",  1'b1, 1'b0, 8'd8,   8'h01, 8'h00, 10);
    run_op("shl_ff_200",1'b1, 1'b0, 8'd200, 8'hFF, 8'h00, 10);
`else
    run_op("rol_01_9",  1'b1, 1'b1, 8'd9,   8'h01, 8'h02, 11);
    run_op("shl_01_8",  1'b1, 1'b0, 8'd8,   8'h01, 8'h00, 10);
    run_op("shl_ff_200",1'b1, 1'b0, 8'd200, 8'hFF, 8'h00, 202);
`endif

    // Stalled response with a second command waiting behind it.
    issue(1'b1, 1'b1, 8'd2, 8'hC3);
    @(posedge clk);
    #1;
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd4);
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_direction  = 1'b0;
    cmd_rotate     = 1'b0;
    cmd_iterations = 8'd4;
    cmd_value      = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_value", 32'(rsp_value), 32'h0F);
      check("stall_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("handoff_valid", 32'(rsp_valid), 32'd0);
    check("handoff_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    wait_rsp(lat);
    check("b2b_lat", 32'(lat), 32'd6);
    check("b2b_val", 32'(rsp_value), 32'h0F);
    take_rsp();

    // Reset while the shifter is mid-run.
    issue(1'b1, 1'b0, 8'd10, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_value", 32'(rsp_value), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op("post_rst", 1'b0, 1'b0, 8'd2, 8'h80, 8'h20, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
